// File: rtl/pipe_reg_chain_if.sv
// Producer/consumer handshake bundle for pipe_reg_chain.
// Valid/ready: a word moves when valid and ready are both high at a rising edge;
// a producer that sees valid=1 with ready=0 keeps valid and data unchanged.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH stages with per-stage valid bits, bubble collapse,
// backpressure via out_ready, stall via en and flush of all contents.
module pipe_reg_chain #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  pipe_reg_chain_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] r;
  logic             full_tail;
  logic             in_fire;
  logic             out_fire;

  // r[i] = !v[i] || r[i+1] unrolled: a stage can take a word if the consumer
  // is ready or any stage from i to the output end is empty.
  always_comb begin
    full_tail = 1'b1;
    r         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      full_tail = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        full_tail = full_tail & v_q[j];
      end
      r[i] = bus.out_ready || !full_tail;
    end
  end

  assign bus.in_ready  = en && !flush && !rst && r[0];
  assign bus.out_valid = v_q[DEPTH-1] && !flush;
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = en && bus.out_valid && bus.out_ready;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (en && !flush) begin
      if (r[0]) begin
        v_d[0] = bus.in_valid;
        if (bus.in_valid) d_d[0] = bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  // Flush drops valid bits only; data registers keep their stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VALUE;
    end else if (flush) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised elastic register chain and the successor to the single enable-gated 32-bit register. It holds WIDTH-bit words in DEPTH stages, and each stage carries its own valid bit. Stages advance with a valid/ready handshake, so empty slots (bubbles) are closed up and backpressure from the consumer stops the chain. It sits between CPU pipeline stages, for example fetch to decode or decode to execute. It provides stall through en and out_ready, and pipeline flush through flush.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
RESET_VALUE, 0, value loaded into every data stage on reset
CW, $clog2(DEPTH+1), width of count (derived; not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  global advance enable; 0 freezes all state
flush  input  1  clears all valid bits
in_valid  input  1  producer has a word
in_data  input  WIDTH  producer word
in_ready  output  1  chain can accept in_data this cycle
out_valid  output  1  word available at stage DEPTH-1
out_data  output  WIDTH  word at stage DEPTH-1
out_ready  input  1  consumer takes the word
count  output  CW  number of valid stages, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Priority order is rst > flush > en.
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input end; stage DEPTH-1 is the output end.
- Reset: after an edge with rst=1:
  - all v[i]=0, all d[i]=RESET_VALUE;
  - out_valid=0, out_data=RESET_VALUE, count=0.
  - While rst=1, in_ready=0.
- Ready chain (combinational):
  - r[DEPTH] = out_ready;
  - r[i] = !v[i] || r[i+1].
  - in_ready = en && !flush && !rst && r[0].
- Output:
  - out_valid = v[DEPTH-1] && !flush.
  - out_data = d[DEPTH-1], which stays stable while out_valid=1 and out_ready=0.
- Fire conditions:
  - out_fire = en && out_valid && out_ready.
  - in_fire = in_valid && in_ready.
- Update on an edge with en=1, flush=0, rst=0, for each stage i where r[i]=1:
  - source valid sv = (i==0 ? in_valid : v[i-1]);
  - v[i] <= sv;
  - d[i] <= source data if sv=1, otherwise d[i] holds.
  - Stages with r[i]=0 hold both v and d.
- Bubble collapse: a word moves forward whenever the stage ahead of it is empty or is itself moving. Backpressure therefore only stalls words behind the first occupied stage that cannot move.
- en=0: all state holds and in_ready=0. out_valid still reflects v[DEPTH-1], but no out_fire occurs.
- flush=1 (rst=0):
  - all v[i] <= 0 on the edge; d[i] holds.
  - in_ready=0 and out_valid=0 during that cycle, so no transfer occurs on either side.
  - flush acts regardless of en.
- Latency: with an empty chain and out_ready=1, a word accepted at edge t is at the output (out_valid=1) after edge t+DEPTH-1. There is no dead cycle; full throughput is 1 word per cycle.
- count:
  - registered; equals popcount(v).
  - Next value = count + in_fire - out_fire.
  - Set to 0 on rst or flush.
- Boundaries:
  - Chain full with out_ready=0: in_ready=0.
  - Chain full with out_ready=1 and en=1: in_ready=1 in the same cycle (combinational pass-through of ready). Simultaneous push and pop leaves count unchanged.
  - Empty chain: out_valid=0, and out_data shows the stale last value.
  - in_valid with in_ready=0: the word is not taken, and the producer must hold it.
  - rst or flush in the middle of a stall discards all contents; no partial transfer.
  - DEPTH=1 degenerates to a single handshaked register.

Test Plan:
1. WIDTH=8, DEPTH=3, RESET_VALUE=0xA5; hold rst=1 for 2 cycles with in_valid=1 and in_data=0x11 -> in_ready=0, out_valid=0, out_data=0xA5, count=0 throughout.
2. Streaming: out_ready=1, en=1; push 0x11, 0x22, 0x33 on consecutive edges t, t+1, t+2 -> out_valid rises after edge t+2; output is 0x11, 0x22, 0x33 on consecutive cycles; in_ready stays 1; count peaks at 3.
3. Backpressure: out_ready=0; offer 0x01..0x04 back-to-back -> first 3 accepted, count=3, in_ready=0 with 0x04 held. Raise out_ready -> in_ready=1 in the same cycle, 0x04 accepted, and output order is 0x01, 0x02, 0x03, 0x04.
4. Bubble collapse: out_ready=0; push 0xAA, idle 2 cycles, push 0xBB -> count=2, out_data=0xAA, and 0xBB sits in stage 1 (in_ready=1, one slot free).
5. Freeze: with 2 words held, set en=0 for 5 cycles with in_valid=1 and out_ready=1 -> in_ready=0, no out_fire, count=2 and all outputs unchanged; after en=1, normal draining resumes.
6. Flush: with 3 words held, assert flush=1 for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0 and out_valid=0. Separately, asserting rst and flush together -> data resets to RESET_VALUE.
